// File: rtl/reservation_station_array_if.sv
// Dispatch / CDB / issue bundle for reservation_station_array.
// master drives dispatch, CDB, flush and issue_ready; slave is the station.
interface reservation_station_array_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 enable;
  logic [TAG_WIDTH-1:0] reorder_buffer_tag_in;
  logic [2:0]           alu_op_in;
  logic                 op1_valid_in, op2_valid_in;
  logic [TAG_WIDTH-1:0] op1_tag_in, op2_tag_in;
  logic [XLEN-1:0]      op1_data_in, op2_data_in;
  logic                 cdb_enable;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [XLEN-1:0]      cdb_data;
  logic                 flush;
  logic                 full;
  logic [CW-1:0]        count;
  logic [DEPTH-1:0]     busy_out;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [TAG_WIDTH-1:0] reorder_buffer_tag_out;
  logic [2:0]           alu_op_out;
  logic [XLEN-1:0]      op1_data_out, op2_data_out;

  modport master (
    output enable, reorder_buffer_tag_in, alu_op_in, op1_valid_in, op2_valid_in,
           op1_tag_in, op2_tag_in, op1_data_in, op2_data_in,
           cdb_enable, cdb_tag, cdb_data, flush, issue_ready,
    input  full, count, busy_out, issue_valid,
           reorder_buffer_tag_out, alu_op_out, op1_data_out, op2_data_out
  );

  modport slave (
    input  enable, reorder_buffer_tag_in, alu_op_in, op1_valid_in, op2_valid_in,
           op1_tag_in, op2_tag_in, op1_data_in, op2_data_in,
           cdb_enable, cdb_tag, cdb_data, flush, issue_ready,
    output full, count, busy_out, issue_valid,
           reorder_buffer_tag_out, alu_op_out, op1_data_out, op2_data_out
  );
endinterface

// File: rtl/reservation_station_array.sv
// DEPTH-entry reservation station: dispatch, CDB wakeup, one issue per cycle.
// Define RS_OLDEST_FIRST_EN for age-ordered select; default is lowest-index select.
module reservation_station_array #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input logic clk,
  input logic reset,
  reservation_station_array_if.slave rs
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 busy;
    logic [TAG_WIDTH-1:0] rob;
    logic [2:0]           op;
    logic                 v1;
    logic [TAG_WIDTH-1:0] t1;
    logic [XLEN-1:0]      d1;
    logic                 v2;
    logic [TAG_WIDTH-1:0] t2;
    logic [XLEN-1:0]      d2;
  } entry_t;

  entry_t           ent [DEPTH];
  entry_t           ent_new;
  logic [DEPTH-1:0] busy, ready, alloc, sel;
  logic [CW-1:0]    cnt;
  logic             issue, hit1, hit2;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && ent[i].v1 && ent[i].v2;
      cnt      = cnt + CW'(ent[i].busy);
    end
  end

  assign rs.busy_out    = busy;
  assign rs.count       = cnt;
  assign rs.full        = (cnt == CW'(DEPTH));
  assign rs.issue_valid = |ready;
  assign issue          = rs.issue_valid && rs.issue_ready;

  // Lowest-index free slot takes the dispatch; nothing is written while full.
  always_comb begin
    alloc = '0;
    if (rs.enable && !rs.full) begin
      for (int i = DEPTH - 1; i >= 0; i--)
        if (!busy[i]) alloc = DEPTH'(1) << i;
    end
  end

  // Incoming operand picks up a matching broadcast in its dispatch cycle.
  always_comb begin
    hit1 = rs.cdb_enable && !rs.op1_valid_in && (rs.op1_tag_in == rs.cdb_tag);
    hit2 = rs.cdb_enable && !rs.op2_valid_in && (rs.op2_tag_in == rs.cdb_tag);
    ent_new      = '0;
    ent_new.busy = 1'b1;
    ent_new.rob  = rs.reorder_buffer_tag_in;
    ent_new.op   = rs.alu_op_in;
    ent_new.v1   = rs.op1_valid_in || hit1;
    ent_new.t1   = rs.op1_tag_in;
    ent_new.d1   = hit1 ? rs.cdb_data : rs.op1_data_in;
    ent_new.v2   = rs.op2_valid_in || hit2;
    ent_new.t2   = rs.op2_tag_in;
    ent_new.d2   = hit2 ? rs.cdb_data : rs.op2_data_in;
  end

`ifdef RS_OLDEST_FIRST_EN
  // older[j][i] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (!rs.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[j][k] <= (j != k);
            older[k][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i]) sel[i] = 1'b0;
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i]) sel = DEPTH'(1) << i;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs.flush) begin
          ent[i].busy <= 1'b0;
        end else if (alloc[i]) begin
          ent[i] <= ent_new;
        end else begin
          if (issue && sel[i]) ent[i].busy <= 1'b0;
          if (rs.cdb_enable && ent[i].busy && !ent[i].v1 && ent[i].t1 == rs.cdb_tag) begin
            ent[i].v1 <= 1'b1;
            ent[i].d1 <= rs.cdb_data;
          end
          if (rs.cdb_enable && ent[i].busy && !ent[i].v2 && ent[i].t2 == rs.cdb_tag) begin
            ent[i].v2 <= 1'b1;
            ent[i].d2 <= rs.cdb_data;
          end
        end
      end
    end
  end

  // sel is one-hot or zero, so an OR-mux yields zeros when nothing is ready.
  always_comb begin
    rs.reorder_buffer_tag_out = '0;
    rs.alu_op_out             = '0;
    rs.op1_data_out           = '0;
    rs.op2_data_out           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        rs.reorder_buffer_tag_out = rs.reorder_buffer_tag_out | ent[i].rob;
        rs.alu_op_out             = rs.alu_op_out | ent[i].op;
        rs.op1_data_out           = rs.op1_data_out | ent[i].d1;
        rs.op2_data_out           = rs.op2_data_out | ent[i].d2;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station_array.sv
// Self-checking bench for reservation_station_array: vector table plus
// hand-written multi-cycle sequences, issue results checked via scoreboard.
module tb_reservation_station_array;
  localparam int XLEN = 32, TW = 32, DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reservation_station_array_if #(.XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) rs();

  reservation_station_array #(.XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rs(rs)
  );

  typedef struct {
    logic [31:0] tag; logic [2:0] op;
    logic v1; logic [31:0] t1, d1;
    logic v2; logic [31:0] t2, d2;
    logic cdb_en; logic [31:0] cdb_tag, cdb_data;
    logic [31:0] exp_d1, exp_d2;
  } vec_t;

  typedef struct { logic [31:0] tag; logic [2:0] op; logic [31:0] d1, d2; } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rs.enable = 0; rs.reorder_buffer_tag_in = 0; rs.alu_op_in = 0;
    rs.op1_valid_in = 0; rs.op2_valid_in = 0; rs.op1_tag_in = 0; rs.op2_tag_in = 0;
    rs.op1_data_in = 0; rs.op2_data_in = 0;
    rs.cdb_enable = 0; rs.cdb_tag = 0; rs.cdb_data = 0;
    rs.flush = 0; rs.issue_ready = 0;
  endtask

  task automatic set_disp(input logic [31:0] tag, input logic [2:0] op,
                          input logic v1, input logic [31:0] t1, input logic [31:0] d1,
                          input logic v2, input logic [31:0] t2, input logic [31:0] d2);
    rs.enable = 1; rs.reorder_buffer_tag_in = tag; rs.alu_op_in = op;
    rs.op1_valid_in = v1; rs.op1_tag_in = t1; rs.op1_data_in = d1;
    rs.op2_valid_in = v2; rs.op2_tag_in = t2; rs.op2_data_in = d2;
  endtask

  task automatic cdb(input logic [31:0] tag, input logic [31:0] data);
    rs.cdb_enable = 1; rs.cdb_tag = tag; rs.cdb_data = data;
  endtask

  task automatic push(input logic [31:0] tag, input logic [2:0] op,
                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.tag = tag; e.op = op; e.d1 = d1; e.d2 = d2;
    q.push_back(e);
  endtask

  // Accept one issue and compare it against the oldest scoreboard entry.
  task automatic do_issue(input string name);
    exp_t e;
    chk({name, ".valid"}, 64'(rs.issue_valid), 64'd1);
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL %s.sb: got issue with empty scoreboard expected none", name);
    end else begin
      e = q.pop_front();
      chk({name, ".tag"}, 64'(rs.reorder_buffer_tag_out), 64'(e.tag));
      chk({name, ".op"},  64'(rs.alu_op_out),             64'(e.op));
      chk({name, ".d1"},  64'(rs.op1_data_out),           64'(e.d1));
      chk({name, ".d2"},  64'(rs.op2_data_out),           64'(e.d2));
    end
    rs.issue_ready = 1;
    tick();
    rs.issue_ready = 0;
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{32'd5,  3'b000, 1, 0, 32'd10,         1, 0, 32'd20, 0, 0, 0,             32'd10,         32'd20};
    vt[1] = '{32'd6,  3'b101, 1, 0, 32'hFFFF_FFFF,  1, 0, 32'd0,  0, 0, 0,             32'hFFFF_FFFF,  32'd0};
    vt[2] = '{32'd8,  3'b010, 0, 3, 32'd0,          1, 0, 32'd7,  1, 3, 32'd42,        32'd42,         32'd7};
    vt[3] = '{32'd11, 3'b111, 0, 4, 32'd0,          0, 4, 32'd0,  1, 4, 32'h1234,      32'h1234,       32'h1234};
    vt[4] = '{32'd12, 3'b001, 1, 4, 32'd100,        1, 0, 32'd9,  1, 4, 32'h55,        32'd100,        32'd9};

    idle();
    tick(); tick();
    chk("rst.busy",  64'(rs.busy_out),    64'd0);
    chk("rst.count", 64'(rs.count),       64'd0);
    chk("rst.full",  64'(rs.full),        64'd0);
    chk("rst.valid", 64'(rs.issue_valid), 64'd0);
    chk("rst.d1",    64'(rs.op1_data_out), 64'd0);
    reset = 1;
    tick();

    // Single-instruction vectors, including dispatch-cycle bypass cases.
    for (int i = 0; i < 5; i++) begin
      set_disp(vt[i].tag, vt[i].op, vt[i].v1, vt[i].t1, vt[i].d1, vt[i].v2, vt[i].t2, vt[i].d2);
      if (vt[i].cdb_en) cdb(vt[i].cdb_tag, vt[i].cdb_data);
      push(vt[i].tag, vt[i].op, vt[i].exp_d1, vt[i].exp_d2);
      tick();
      idle();
      chk($sformatf("vec%0d.count", i), 64'(rs.count), 64'd1);
      do_issue($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.drain", i), 64'(rs.count), 64'd0);
    end

    // Wakeup two cycles after dispatch; no same-cycle forwarding.
    set_disp(32'd7, 3'b011, 1, 0, 32'd1, 0, 32'd9, 0);
    tick(); idle();
    chk("wk.wait0", 64'(rs.issue_valid), 64'd0);
    tick();
    cdb(32'd9, 32'hDEAD_BEEF);
    chk("wk.nofwd", 64'(rs.issue_valid), 64'd0);
    tick(); idle();
    push(32'd7, 3'b011, 32'd1, 32'hDEAD_BEEF);
    do_issue("wk");

    // Fill, drop while full, simultaneous dispatch+issue while full.
    for (int i = 0; i < 4; i++) begin
      set_disp(32'(10 + i), 3'(i), 0, 32'd50, 0, 1, 0, 32'(i));
      tick();
    end
    idle();
    chk("full.full",  64'(rs.full),        64'd1);
    chk("full.count", 64'(rs.count),       64'd4);
    chk("full.busy",  64'(rs.busy_out),    64'hF);
    chk("full.valid", 64'(rs.issue_valid), 64'd0);
    set_disp(32'd99, 3'b000, 1, 0, 32'd1, 1, 0, 32'd2);
    tick(); idle();
    chk("full.drop", 64'(rs.count), 64'd4);
    cdb(32'd50, 32'hABC);
    tick(); idle();
    for (int i = 0; i < 4; i++) push(32'(10 + i), 3'(i), 32'hABC, 32'(i));
    set_disp(32'd99, 3'b000, 1, 0, 32'd1, 1, 0, 32'd2);
    do_issue("full.iss0");
    idle();
    chk("full.cnt3", 64'(rs.count), 64'd3);
    chk("full.nf",   64'(rs.full),  64'd0);
    for (int i = 1; i < 4; i++) do_issue($sformatf("full.iss%0d", i));
    chk("full.empty", 64'(rs.count),       64'd0);
    chk("full.nov",   64'(rs.issue_valid), 64'd0);

    // Older entry sitting at the higher index.
    set_disp(32'd30, 3'b000, 1, 0, 32'd3, 1, 0, 32'd4);
    tick();
    set_disp(32'd31, 3'b001, 0, 32'd70, 0, 1, 0, 32'd1);
    tick(); idle();
    push(32'd30, 3'b000, 32'd3, 32'd4);
    do_issue("age.x");
    set_disp(32'd32, 3'b010, 1, 0, 32'd5, 1, 0, 32'd6);
    tick(); idle();
    chk("age.busy", 64'(rs.busy_out), 64'h3);
    cdb(32'd70, 32'h77);
    tick(); idle();
`ifdef RS_OLDEST_FIRST_EN
    push(32'd31, 3'b001, 32'h77, 32'd1);
    push(32'd32, 3'b010, 32'd5, 32'd6);
`else
    push(32'd32, 3'b010, 32'd5, 32'd6);
    push(32'd31, 3'b001, 32'h77, 32'd1);
`endif
    do_issue("age.first");
    do_issue("age.second");

    // Flush with concurrent dispatch and issue.
    for (int i = 0; i < 3; i++) begin
      set_disp(32'(40 + i), 3'b000, 1, 0, 32'(i), 1, 0, 32'(i));
      tick();
    end
    idle();
    chk("fl.count3", 64'(rs.count), 64'd3);
    set_disp(32'd43, 3'b000, 1, 0, 32'd1, 1, 0, 32'd1);
    rs.flush = 1; rs.issue_ready = 1;
    tick(); idle();
    chk("fl.count", 64'(rs.count),       64'd0);
    chk("fl.valid", 64'(rs.issue_valid), 64'd0);
    chk("fl.busy",  64'(rs.busy_out),    64'd0);

    // Stall holds outputs; async reset clears them without an edge.
    set_disp(32'd50, 3'b110, 1, 0, 32'd1, 1, 0, 32'd2);
    tick(); idle();
    chk("st.valid", 64'(rs.issue_valid), 64'd1);
    tick();
    chk("st.hold", 64'(rs.reorder_buffer_tag_out), 64'd50);
    chk("st.d2",   64'(rs.op2_data_out),           64'd2);
    #2 reset = 0;
    #1;
    chk("ar.valid", 64'(rs.issue_valid),            64'd0);
    chk("ar.count", 64'(rs.count),                  64'd0);
    chk("ar.tag",   64'(rs.reorder_buffer_tag_out), 64'd0);
    reset = 1;
    tick();
    set_disp(32'd60, 3'b100, 1, 0, 32'd8, 1, 0, 32'd9);
    push(32'd60, 3'b100, 32'd8, 32'd9);
    tick(); idle();
    do_issue("resume");
    chk("sb.empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
